// File: rtl/cpu_r_defs.sv
// Shared encodings for the R-type control path: FSM states, MIPS func codes
// and the ALU operation selects driven toward the datapath.
package cpu_r_defs;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;

  localparam logic [5:0] FUNC_SLL  = 6'h00;
  localparam logic [5:0] FUNC_SRL  = 6'h02;
  localparam logic [5:0] FUNC_ADD  = 6'h20;
  localparam logic [5:0] FUNC_ADDU = 6'h21;
  localparam logic [5:0] FUNC_SUB  = 6'h22;
  localparam logic [5:0] FUNC_SUBU = 6'h23;
  localparam logic [5:0] FUNC_AND  = 6'h24;
  localparam logic [5:0] FUNC_OR   = 6'h25;
  localparam logic [5:0] FUNC_XOR  = 6'h26;
  localparam logic [5:0] FUNC_NOR  = 6'h27;
  localparam logic [5:0] FUNC_SLT  = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_XOR = 4'b1101;
  localparam logic [3:0] ALU_SLL = 4'b1110;
  localparam logic [3:0] ALU_SRL = 4'b1111;

endpackage

// File: rtl/r_type_controller_if.sv
// Controller <-> datapath signals: decoded instruction fields and ALU flag in,
// per-stage write strobes and ALU select out.
interface r_type_controller_if;
  logic [5:0] op_code;
  logic [5:0] func;
  logic       alu_of;
  logic       pc_we;
  logic       ir_we;
  logic       ab_we;
  logic       alu_we;
  logic [3:0] alu_op;
  logic       rf_we;

  modport master (
    input  op_code, func, alu_of,
    output pc_we, ir_we, ab_we, alu_we, alu_op, rf_we
  );

  modport slave (
    output op_code, func, alu_of,
    input  pc_we, ir_we, ab_we, alu_we, alu_op, rf_we
  );
endinterface

// File: rtl/r_func_decoder.sv
// Combinational R-type decode: func -> ALU select, legality and whether the
// operation traps on signed overflow.
module r_func_decoder
  import cpu_r_defs::*;
(
  input  logic [5:0] op_code,
  input  logic [5:0] func,
  output logic [3:0] alu_op,
  output logic       legal,
  output logic       ov_check
);

  always_comb begin
    alu_op   = ALU_AND;
    legal    = 1'b1;
    ov_check = 1'b0;
    case (func)
      FUNC_ADD:  begin alu_op = ALU_ADD; ov_check = 1'b1; end
      FUNC_ADDU: alu_op = ALU_ADD;
      FUNC_SUB:  begin alu_op = ALU_SUB; ov_check = 1'b1; end
      FUNC_SUBU: alu_op = ALU_SUB;
      FUNC_AND:  alu_op = ALU_AND;
      FUNC_OR:   alu_op = ALU_OR;
      FUNC_XOR:  alu_op = ALU_XOR;
      FUNC_NOR:  alu_op = ALU_NOR;
      FUNC_SLT:  alu_op = ALU_SLT;
      FUNC_SLL:  alu_op = ALU_SLL;
      FUNC_SRL:  alu_op = ALU_SRL;
      default:   legal  = 1'b0;
    endcase
    // Any non-R-type opcode is rejected regardless of the func field.
    if (op_code != OP_RTYPE || !legal) begin
      alu_op   = ALU_AND;
      legal    = 1'b0;
      ov_check = 1'b0;
    end
  end

endmodule

// File: rtl/r_type_controller.sv
// Multi-cycle R-type sequencer: one datapath strobe per stage, free-run or
// single-step, with retired-instruction count and sticky fault flags.
//
// state  | meaning
// IDLE   | waiting for run or a step pulse
// FETCH  | load IR, advance PC
// DECODE | latch A/B, decode func into alu_op
// EXEC   | latch ALU result, capture overflow
// WB     | write rd unless overflow trapped, count the instruction
// HALT   | illegal instruction seen; only reset leaves
module r_type_controller
  import cpu_r_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  Reset_n,
  input  logic                  run,
  input  logic                  step,
  r_type_controller_if.master   dp,
  output logic                  busy,
  output logic                  illegal,
  output logic                  overflow,
  output logic [CNT_W-1:0]      retired
);

  state_t     state;
  logic [3:0] dec_alu_op;
  logic       dec_legal;
  logic       dec_ov_check;
  logic       ov_check_q;
  logic       ov_pending;

  r_func_decoder u_dec (
    .op_code  (dp.op_code),
    .func     (dp.func),
    .alu_op   (dec_alu_op),
    .legal    (dec_legal),
    .ov_check (dec_ov_check)
  );

  assign busy = (state != ST_IDLE) && (state != ST_HALT);

  // Strobes are assigned together with the state they belong to, so they are
  // registered yet track the state register exactly.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_IDLE;
      dp.pc_we    <= 1'b0;
      dp.ir_we    <= 1'b0;
      dp.ab_we    <= 1'b0;
      dp.alu_we   <= 1'b0;
      dp.rf_we    <= 1'b0;
      dp.alu_op   <= ALU_AND;
      ov_check_q  <= 1'b0;
      ov_pending  <= 1'b0;
      illegal     <= 1'b0;
      overflow    <= 1'b0;
      retired     <= '0;
    end else begin
      dp.pc_we  <= 1'b0;
      dp.ir_we  <= 1'b0;
      dp.ab_we  <= 1'b0;
      dp.alu_we <= 1'b0;
      dp.rf_we  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run || step) begin
            state    <= ST_FETCH;
            dp.ir_we <= 1'b1;
            dp.pc_we <= 1'b1;
          end
        end
        ST_FETCH: begin
          state    <= ST_DECODE;
          dp.ab_we <= 1'b1;
        end
        ST_DECODE: begin
          dp.alu_op  <= dec_alu_op;
          ov_check_q <= dec_ov_check;
          if (!dec_legal) begin
            illegal <= 1'b1;
            state   <= ST_HALT;
          end else begin
            state     <= ST_EXEC;
            dp.alu_we <= 1'b1;
          end
        end
        ST_EXEC: begin
          ov_pending <= dp.alu_of & ov_check_q;
          dp.rf_we   <= ~(dp.alu_of & ov_check_q);
          state      <= ST_WB;
        end
        ST_WB: begin
          if (ov_pending) overflow <= 1'b1;
          retired <= retired + CNT_W'(1);
          if (run) begin
            state    <= ST_FETCH;
            dp.ir_we <= 1'b1;
            dp.pc_we <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_r_type_controller.sv
// Scoreboard bench for r_type_controller: stimulus queues the expected
// per-cycle strobe pattern, a negedge monitor pops it on every busy cycle.
module tb_r_type_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        busy;
  logic        illegal;
  logic        overflow;
  logic [31:0] retired;

  r_type_controller_if dp_if ();

  r_type_controller #(.CNT_W(32)) dut (
    .clk      (clk),
    .Reset_n  (rst_n),
    .run      (run),
    .step     (step),
    .dp       (dp_if),
    .busy     (busy),
    .illegal  (illegal),
    .overflow (overflow),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  strb;    // {ir_we, pc_we, ab_we, alu_we, rf_we}
    logic        chk_op;
    logic [3:0]  op;
    logic [31:0] ret;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_ret = 0;
  logic        exp_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [4:0] s, input logic c, input logic [3:0] o);
    exp_t e;
    e.strb = s; e.chk_op = c; e.op = o; e.ret = exp_ret; e.ovf = exp_ovf;
    exp_q.push_back(e);
  endtask

  // Monitor
  exp_t       mon_e;
  logic [4:0] mon_s;
  always @(negedge clk) begin
    if (rst_n) begin
      mon_s = {dp_if.ir_we, dp_if.pc_we, dp_if.ab_we, dp_if.alu_we, dp_if.rf_we};
      if (busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_busy actual=busy strobes=%b expected=idle t=%0t", mon_s, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("strobes", 32'(mon_s), 32'(mon_e.strb));
          if (mon_e.chk_op) chk("alu_op", 32'(dp_if.alu_op), 32'(mon_e.op));
          chk("retired_busy", retired, mon_e.ret);
          chk("overflow_busy", 32'(overflow), 32'(mon_e.ovf));
          chk("illegal_busy", 32'(illegal), 32'd0);
        end
      end else begin
        chk("idle_strobes", 32'(mon_s), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name, input logic [31:0] r, input logic o, input logic il);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_strobes"}, 32'({dp_if.ir_we, dp_if.pc_we, dp_if.ab_we, dp_if.alu_we, dp_if.rf_we}), 32'd0);
    chk({name, "_retired"}, retired, r);
    chk({name, "_overflow"}, 32'(overflow), 32'(o));
    chk({name, "_illegal"}, 32'(illegal), 32'(il));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    step = 1'b0;
    exp_q.delete();
    exp_ret = 0;
    exp_ovf = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Called one cycle before FETCH (DUT in IDLE with run/step applied, or in WB).
  task automatic issue(input logic [5:0] f, input logic of, input logic [3:0] eop,
                       input logic erf, input logic use_step, input logic last,
                       input logic extra_step);
    dp_if.op_code = 6'b000000;
    dp_if.func    = f;
    dp_if.alu_of  = of;
    if (use_step) step = 1'b1;
    push(5'b11000, 1'b0, 4'd0);
    push(5'b00100, 1'b0, 4'd0);
    push(5'b00010, 1'b1, eop);
    push({4'b0000, erf}, 1'b1, eop);
    tick(); step = 1'b0;
    tick();
    tick(); if (extra_step) step = 1'b1;
    tick(); step = 1'b0;
    if (last) run = 1'b0;
    exp_ret = exp_ret + 1;
    if (!erf) exp_ovf = 1'b1;
  endtask

  task automatic issue_illegal(input logic [5:0] op, input logic [5:0] f, input logic use_step);
    dp_if.op_code = op;
    dp_if.func    = f;
    dp_if.alu_of  = 1'b0;
    if (use_step) step = 1'b1;
    push(5'b11000, 1'b0, 4'd0);
    push(5'b00100, 1'b0, 4'd0);
    tick(); step = 1'b0;
    tick();
    tick();
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_illegal", 32'(illegal), 32'd1);
    // run and step must not restart the FSM from HALT
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step = i[0];
      tick();
    end
    step = 1'b0;
  endtask

  logic [5:0] burst_f  [7] = '{6'h21, 6'h24, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02};
  logic [3:0] burst_op [7] = '{4'b0010, 4'b0000, 4'b1101, 4'b1100, 4'b0111, 4'b1110, 4'b1111};

  initial begin
    dp_if.op_code = 6'd0;
    dp_if.func    = 6'd0;
    dp_if.alu_of  = 1'b0;
    do_reset();
    repeat (4) tick();
    check_idle("reset", 0, 1'b0, 1'b0);
    chk("reset_alu_op", 32'(dp_if.alu_op), 32'd0);

    // two back-to-back adds
    run = 1'b1;
    issue(6'h20, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(6'h20, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    check_idle("run_add", 2, 1'b0, 1'b0);

    // single step of OR, with a stray step pulse during EXEC
    issue(6'h25, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (4) tick();
    check_idle("step_or", 3, 1'b0, 1'b0);

    // remaining ops; alu_of high must not trap unchecked ops
    run = 1'b1;
    for (int i = 0; i < 7; i++)
      issue(burst_f[i], 1'b1, burst_op[i], 1'b1, 1'b0, (i == 6), 1'b0);
    repeat (3) tick();
    check_idle("burst", 10, 1'b0, 1'b0);

    // sub overflows (write suppressed), subu with overflow writes
    run = 1'b1;
    issue(6'h22, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(6'h23, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    check_idle("sub_ovf", 12, 1'b1, 1'b0);

    // unsupported func -> HALT
    run = 1'b1;
    issue_illegal(6'h00, 6'h3F, 1'b0);
    check_idle("halt_func", 12, 1'b1, 1'b1);

    do_reset();
    tick();
    check_idle("reset2", 0, 1'b0, 1'b0);

    // non-R-type opcode via step -> HALT
    issue_illegal(6'b100011, 6'h20, 1'b1);
    check_idle("halt_op", 0, 1'b0, 1'b1);

    do_reset();
    tick();
    check_idle("reset3", 0, 1'b0, 1'b0);

    // reset during EXEC aborts the instruction
    run = 1'b1;
    issue(6'h22, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    dp_if.func   = 6'h20;
    dp_if.alu_of = 1'b0;
    push(5'b11000, 1'b0, 4'd0);
    push(5'b00100, 1'b0, 4'd0);
    tick();
    tick();
    tick();
    chk("pre_abort_retired", retired, 32'd1);
    chk("pre_abort_overflow", 32'(overflow), 32'd1);
    chk("pre_abort_alu_we", 32'(dp_if.alu_we), 32'd1);
    rst_n = 1'b0;
    run = 1'b0;
    #1;
    check_idle("abort", 0, 1'b0, 1'b0);
    exp_q.delete();
    exp_ret = 0;
    exp_ovf = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check_idle("after_abort", 0, 1'b0, 1'b0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
